// File: rtl/irig_b_encoder_pkg.sv
// irig_pkg: IRIG-B symbol encodings, pulse widths and frame map shared by the encoder.
package irig_pkg;
    typedef enum logic [1:0] {ZERO = 2'b00, ONE = 2'b01, MARK = 2'b10} bit_t;
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [3:0] W_ZERO = 4'd2, W_ONE = 4'd5, W_MARK = 4'd8;
    localparam int SLOTS_PER_BIT = 10, FRAME_BITS = 100;
    localparam int SEC_U = 1, SEC_T = 6, MIN_U = 10, MIN_T = 15, HR_U = 20, HR_T = 25;
    localparam int DAY_U = 30, DAY_T = 35, DAY_H = 40, SBS_LO = 80, SBS_HI = 90;

    function automatic logic is_marker(input logic [6:0] idx);
        return idx == 7'd0 || idx % 7'd10 == 7'd9;
    endfunction

    function automatic logic [3:0] pulse_width(input bit_t t);
        return t == MARK ? W_MARK : t == ONE ? W_ONE : W_ZERO;
    endfunction

    function automatic bit_t bit_type_of(input logic [6:0] idx, input logic [6:0] sec,
                                         input logic [6:0] min, input logic [5:0] hr,
                                         input logic [9:0] day, input logic [16:0] sbs);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[SEC_U+:4] = sec[3:0];
        f[SEC_T+:3] = sec[6:4];
        f[MIN_U+:4] = min[3:0];
        f[MIN_T+:3] = min[6:4];
        f[HR_U+:4] = hr[3:0];
        f[HR_T+:2] = hr[5:4];
        f[DAY_U+:4] = day[3:0];
        f[DAY_T+:4] = day[7:4];
        f[DAY_H+:2] = day[9:8];
        f[SBS_LO+:9] = sbs[8:0];
        f[SBS_HI+:8] = sbs[16:9];
        return is_marker(idx) ? MARK : f[idx] ? ONE : ZERO;
    endfunction
endpackage

// File: rtl/irig_bit_timer.sv
// irig_bit_timer: ms tick counter and 10-slot bit-cell counter, held at zero while clear is high.
module irig_bit_timer
    import irig_pkg::*;
#(
    parameter int CLK_PER_MS = 100000,
    parameter int MS_CNT_W = $clog2(CLK_PER_MS)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    output logic [3:0] slot,
    output logic       slot_end,
    output logic       bit_end
);
    logic [MS_CNT_W-1:0] ms;

    assign slot_end = ms == MS_CNT_W'(CLK_PER_MS - 1);
    assign bit_end = slot_end && slot == 4'(SLOTS_PER_BIT - 1);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            ms <= '0;
            slot <= '0;
        end else begin
            ms <= slot_end ? '0 : ms + 1'b1;
            slot <= bit_end ? 4'd0 : slot_end ? slot + 4'd1 : slot;
        end
    end
endmodule

// File: rtl/irig_b_encoder.sv
// irig_b_encoder: IRIG-B DC level-shift encoder from latched BCD time.
// Define IRIG_SBS_EN to add the sbs_in port and transmit straight binary seconds in bits 80-97.
module irig_b_encoder
    import irig_pkg::*;
#(
    parameter int CLK_PER_MS = 100000,
    parameter int MS_CNT_W = $clog2(CLK_PER_MS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [6:0]  sec_bcd,
    input  logic [6:0]  min_bcd,
    input  logic [5:0]  hr_bcd,
    input  logic [9:0]  day_bcd,
`ifdef IRIG_SBS_EN
    input  logic [16:0] sbs_in,
`endif
    output logic        irig_out,
    output logic        frame_start,
    output logic [6:0]  bit_idx,
    output logic [1:0]  bit_type
);
    state_t state, state_nxt;
    bit_t type_q, type_nxt;
    logic [6:0] idx_nxt, sec_q, min_q;
    logic [5:0] hr_q;
    logic [9:0] day_q;
    logic [16:0] sbs_q, sbs_now;
    logic [3:0] slot, slot_nxt;
    logic slot_end, bit_end, load, irig_nxt;

`ifdef IRIG_SBS_EN
    assign sbs_now = sbs_in;
`else
    assign sbs_now = '0;
`endif

    irig_bit_timer #(.CLK_PER_MS(CLK_PER_MS), .MS_CNT_W(MS_CNT_W)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .clear(state == IDLE),
        .slot(slot),
        .slot_end(slot_end),
        .bit_end(bit_end)
    );

    assign bit_type = type_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            bit_idx <= '0;
            frame_start <= 1'b0;
            irig_out <= 1'b0;
            type_q <= ZERO;
            sec_q <= '0;
            min_q <= '0;
            hr_q <= '0;
            day_q <= '0;
            sbs_q <= '0;
        end else begin
            state <= state_nxt;
            bit_idx <= idx_nxt;
            frame_start <= load;
            irig_out <= irig_nxt;
            type_q <= type_nxt;
            if (load) begin
                sec_q <= sec_bcd;
                min_q <= min_bcd;
                hr_q <= hr_bcd;
                day_q <= day_bcd;
                sbs_q <= sbs_now;
            end
        end
    end

    // Outputs are registered, so everything is computed for the cycle about to begin.
    always_comb begin
        state_nxt = state;
        idx_nxt = bit_idx;
        load = 1'b0;
        if (state == IDLE) begin
            if (en) begin
                state_nxt = RUN;
                load = 1'b1;
                idx_nxt = '0;
            end
        end else if (bit_end) begin
            if (bit_idx == 7'(FRAME_BITS - 1)) begin
                idx_nxt = '0;
                load = en;
                state_nxt = en ? RUN : IDLE;
            end else begin
                idx_nxt = bit_idx + 7'd1;
            end
        end
        slot_nxt = bit_end ? 4'd0 : slot_end ? slot + 4'd1 : slot;
        type_nxt = state_nxt == RUN ? bit_type_of(idx_nxt, load ? sec_bcd : sec_q,
                                                  load ? min_bcd : min_q, load ? hr_bcd : hr_q,
                                                  load ? day_bcd : day_q, load ? sbs_now : sbs_q)
                                    : ZERO;
        irig_nxt = state_nxt == RUN && slot_nxt < pulse_width(type_nxt);
    end
endmodule

// File: tb/tb_irig_b_encoder.sv
// tb_irig_b_encoder: directed frame sequence with random time values against a frame-map model.
module tb_irig_b_encoder;
    localparam int CPM = 4, CPB = CPM * 10, CPF = CPB * 100;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [6:0] sec_bcd, min_bcd;
    logic [5:0] hr_bcd;
    logic [9:0] day_bcd;
`ifdef IRIG_SBS_EN
    logic [16:0] sbs_in;
`endif
    logic irig_out, frame_start;
    logic [6:0] bit_idx;
    logic [1:0] bit_type;

    int errors = 0, checks = 0;
    int m_ty[100];
    int obs_ty[100];
    int obs_hi[100];

    always #5 clk = ~clk;

    irig_b_encoder #(.CLK_PER_MS(CPM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .sec_bcd(sec_bcd),
        .min_bcd(min_bcd),
        .hr_bcd(hr_bcd),
        .day_bcd(day_bcd),
`ifdef IRIG_SBS_EN
        .sbs_in(sbs_in),
`endif
        .irig_out(irig_out),
        .frame_start(frame_start),
        .bit_idx(bit_idx),
        .bit_type(bit_type)
    );

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: got %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    function automatic int width_of(input int ty);
        return ty == 2 ? 8 : ty == 1 ? 5 : 2;
    endfunction

    task automatic put(input int pos, input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) m_ty[pos + i] = v[i] ? 1 : 0;
    endtask

    task automatic build_model();
        for (int i = 0; i < 100; i++) m_ty[i] = 0;
        put(1, 32'(sec_bcd[3:0]), 4);
        put(6, 32'(sec_bcd[6:4]), 3);
        put(10, 32'(min_bcd[3:0]), 4);
        put(15, 32'(min_bcd[6:4]), 3);
        put(20, 32'(hr_bcd[3:0]), 4);
        put(25, 32'(hr_bcd[5:4]), 2);
        put(30, 32'(day_bcd[3:0]), 4);
        put(35, 32'(day_bcd[7:4]), 4);
        put(40, 32'(day_bcd[9:8]), 2);
`ifdef IRIG_SBS_EN
        put(80, 32'(sbs_in), 9);
        put(90, 32'(sbs_in) >> 9, 8);
`endif
        m_ty[0] = 2;
        for (int k = 9; k < 100; k += 10) m_ty[k] = 2;
    endtask

    task automatic randomize_inputs();
        sec_bcd = 7'($urandom);
        min_bcd = 7'($urandom);
        hr_bcd = 6'($urandom);
        day_bcd = 10'($urandom);
`ifdef IRIG_SBS_EN
        sbs_in = 17'($urandom);
`endif
    endtask

    // action: 1 randomize inputs at bit 50, 2 clear seconds at bit 50, 3 drop en at bit 50, 4 reset in bit 37
    task automatic run_frame(input int action);
        build_model();
        for (int t = 0; t < CPF; t++) begin
            int b, s;
            b = t / CPB;
            s = (t % CPB) / CPM;
            if (t % CPB == 0) begin
                obs_hi[b] = 0;
                obs_ty[b] = int'(bit_type);
                chk("bit_idx", b, 32'(bit_idx), b);
                chk("bit_type", b, 32'(bit_type), m_ty[b]);
            end
            obs_hi[b] += int'(irig_out);
            chk("irig_out", t, 32'(irig_out), 32'(s < width_of(m_ty[b])));
            chk("frame_start", t, 32'(frame_start), 32'(t == 0));
            if (t % CPB == CPB - 1) chk("high_cycles", b, obs_hi[b], CPM * width_of(m_ty[b]));
            if (t == 50 * CPB + 3) begin
                if (action == 1) randomize_inputs();
                if (action == 2) sec_bcd = 7'h00;
                if (action == 3) en = 1'b0;
            end
            if (action == 4 && t == 37 * CPB + 10) begin
                rst_n = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_irig_out", i, 32'(irig_out), 0);
            chk("idle_frame_start", i, 32'(frame_start), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [16:0] sbs_ref;
        int exp_ty;
        sbs_ref = 17'h1_5180;
        rst_n = 1'b0;
        en = 1'b1;
        randomize_inputs();
        repeat (3) begin
            @(negedge clk);
            chk("rst_irig_out", 0, 32'(irig_out), 0);
            chk("rst_frame_start", 0, 32'(frame_start), 0);
            chk("rst_bit_idx", 0, 32'(bit_idx), 0);
            chk("rst_bit_type", 0, 32'(bit_type), 0);
        end
        sec_bcd = 7'h59;
        min_bcd = 7'h30;
        hr_bcd = 6'h12;
        day_bcd = 10'h123;
`ifdef IRIG_SBS_EN
        sbs_in = sbs_ref;
`endif
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(1);
        chk("bit0_high", 0, obs_hi[0], 32);
        chk("bit1_high", 1, obs_hi[1], 20);
        chk("bit2_high", 2, obs_hi[2], 8);
        chk("day_tens", 35, obs_ty[35], 0);
        chk("day_tens", 36, obs_ty[36], 1);
        chk("day_tens", 37, obs_ty[37], 0);
        chk("day_tens", 38, obs_ty[38], 0);
        for (int i = 0; i < 17; i++) begin
`ifdef IRIG_SBS_EN
            exp_ty = int'(sbs_ref[i]);
`else
            exp_ty = 0;
`endif
            chk("sbs_bit", i < 9 ? 80 + i : 81 + i, obs_ty[i < 9 ? 80 + i : 81 + i], exp_ty);
        end
        run_frame(2);
        chk("p0_high", 99, obs_hi[99], 32);
        chk("pr_high", 0, obs_hi[0], 32);
        run_frame(3);
        for (int i = 1; i <= 8; i++) chk("sec_cleared", i, obs_ty[i], 0);
        check_idle(80);
        randomize_inputs();
        en = 1'b1;
        @(negedge clk);
        run_frame(4);
        @(negedge clk);
        chk("midrst_irig_out", 0, 32'(irig_out), 0);
        chk("midrst_bit_idx", 0, 32'(bit_idx), 0);
        chk("midrst_frame_start", 0, 32'(frame_start), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(3);
        check_idle(40);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
